regw_arbiter: RTL and testbench

Arbiter that shares the register file's single write port (`bus_w`/`addr_w`/`en_w`) among three writers: ALU writeback, the load unit and the debug host. It sits between the requesters and `register_file`. The ALU has fixed priority, subject to a starvation limit. The two secondary writers are served round-robin. Accepted writes are registered and presented to the register file one cycle after acceptance.

---
 rtl/regw_arbiter.sv | 71 +++++++
 tb/tb_regw_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regw_arbiter.sv
// regw_arbiter: shares the register-file write port among ALU, load unit and debug host with a starvation guard
module regw_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              en_w,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] bus_w,
  output logic [1:0]        grant_id
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic              rr_q, rr_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [1:0]        gid_q, gid_d;
  logic              sec_any, pick_dbg, grant_sec, grant_alu;
  always_comb begin
    sec_any   = ld_valid | dbg_valid;
    pick_dbg  = dbg_valid & (~ld_valid | rr_q);
    grant_sec = sec_any & ((starve_q == LIM) | ~alu_valid);
    grant_alu = alu_valid & ~grant_sec;
    alu_ready = ~reset & grant_alu;
    ld_ready  = ~reset & grant_sec & ~pick_dbg;
    dbg_ready = ~reset & grant_sec & pick_dbg;
    rr_d      = grant_sec ? ~pick_dbg : rr_q;
    starve_d  = (grant_sec | ~sec_any) ? '0 : (starve_q == LIM) ? starve_q : starve_q + 1'b1;
    en_d      = grant_alu | grant_sec;
    gid_d     = grant_alu ? 2'd0 : !grant_sec ? 2'd3 : pick_dbg ? 2'd2 : 2'd1;
    addr_d    = grant_alu ? alu_addr : !grant_sec ? addr_q : pick_dbg ? dbg_addr : ld_addr;
    bus_d     = grant_alu ? alu_data : !grant_sec ? bus_q : pick_dbg ? dbg_data : ld_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= 1'b0;
      starve_q <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      bus_q    <= '0;
      gid_q    <= 2'd3;
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      bus_q    <= bus_d;
      gid_q    <= gid_d;
    end
  end
  assign en_w     = en_q;
  assign addr_w   = addr_q;
  assign bus_w    = bus_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_regw_arbiter.sv
// tb_regw_arbiter: directed stimulus with a per-cycle winner model and literal checks
module tb_regw_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alu_valid = 1'b0, ld_valid = 1'b0, dbg_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, ld_addr = '0, dbg_addr = '0;
  logic [DW-1:0] alu_data = '0, ld_data = '0, dbg_data = '0;
  logic alu_ready, ld_ready, dbg_ready, en_w;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] bus_w;
  logic [1:0] grant_id;
  int errs = 0;
  int checks = 0;
  logic m_en = 1'b0, n_en = 1'b0;
  logic [AW-1:0] m_addr = '0, n_addr = '0;
  logic [DW-1:0] m_bus = '0, n_bus = '0;
  logic [1:0] m_gid = 2'd3, n_gid = 2'd3;
  logic m_pref = 1'b0, n_pref = 1'b0;
  int m_wait = 0, n_wait = 0;
  regw_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .en_w(en_w), .addr_w(addr_w), .bus_w(bus_w), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int winner(input logic rst, input logic av, input logic lv, input logic dv,
                                input logic pref, input int waitc);
    int p;
    p = (lv && dv) ? (pref ? 2 : 1) : lv ? 1 : dv ? 2 : 3;
    if (rst) return 3;
    if (p != 3 && waitc >= LIM) return p;
    if (av) return 0;
    return p;
  endfunction
  function automatic int cur_win();
    return winner(reset, alu_valid, ld_valid, dbg_valid, m_pref, m_wait);
  endfunction
  always @(negedge clk) begin
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, cur_win() == 0});
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, cur_win() == 1});
    chk("dbg_ready", {31'b0, dbg_ready}, {31'b0, cur_win() == 2});
    chk("en_w", {31'b0, en_w}, {31'b0, m_en});
    chk("grant_id", {30'b0, grant_id}, {30'b0, m_gid});
    chk("addr_w", {29'b0, addr_w}, {29'b0, m_addr});
    chk("bus_w", {16'b0, bus_w}, {16'b0, m_bus});
    n_pref <= (cur_win() == 1) ? 1'b1 : (cur_win() == 2) ? 1'b0 : m_pref;
    n_wait <= (cur_win() == 1 || cur_win() == 2 || !(ld_valid || dbg_valid)) ? 0 :
              (m_wait < LIM ? m_wait + 1 : LIM);
    n_en   <= cur_win() != 3;
    n_gid  <= 2'(cur_win());
    n_addr <= cur_win() == 0 ? alu_addr : cur_win() == 1 ? ld_addr : cur_win() == 2 ? dbg_addr : m_addr;
    n_bus  <= cur_win() == 0 ? alu_data : cur_win() == 1 ? ld_data : cur_win() == 2 ? dbg_data : m_bus;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en <= 1'b0; m_addr <= '0; m_bus <= '0; m_gid <= 2'd3; m_pref <= 1'b0; m_wait <= 0;
    end else begin
      m_en <= n_en; m_addr <= n_addr; m_bus <= n_bus; m_gid <= n_gid; m_pref <= n_pref; m_wait <= n_wait;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0; dbg_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    int n, at;
    do_reset();
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'hBEEF;
    #2 chk("t1 alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    #2;
    chk("t1 en_w", {31'b0, en_w}, 32'd1);
    chk("t1 addr_w", {29'b0, addr_w}, 32'd5);
    chk("t1 bus_w", {16'b0, bus_w}, 32'hBEEF);
    chk("t1 grant_id", {30'b0, grant_id}, 32'd0);
    tick();
    #2;
    chk("t1 idle en_w", {31'b0, en_w}, 32'd0);
    chk("t1 idle grant_id", {30'b0, grant_id}, 32'd3);
    do_reset();
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'h1111;
    dbg_valid = 1'b1; dbg_addr = 3'd2; dbg_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2 ld_ready", {31'b0, ld_ready}, {31'b0, i % 2 == 0});
      chk("t2 dbg_ready", {31'b0, dbg_ready}, {31'b0, i % 2 == 1});
      if (i > 0) begin
        chk("t2 en_w", {31'b0, en_w}, 32'd1);
        chk("t2 grant_id", {30'b0, grant_id}, (i % 2 == 1) ? 32'd1 : 32'd2);
      end
      tick();
    end
    ld_valid = 1'b0; dbg_valid = 1'b0;
    #2;
    chk("t2 last en_w", {31'b0, en_w}, 32'd1);
    chk("t2 last grant_id", {30'b0, grant_id}, 32'd2);
    tick();
    #2 chk("t2 drain en_w", {31'b0, en_w}, 32'd0);
    do_reset();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hAAAA;
    ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3 alu_ready", {31'b0, alu_ready}, {31'b0, i < 4});
      chk("t3 ld_ready", {31'b0, ld_ready}, {31'b0, i == 4});
      tick();
    end
    ld_valid = 1'b0;
    #2;
    chk("t3 grant_id", {30'b0, grant_id}, 32'd1);
    chk("t3 addr_w", {29'b0, addr_w}, 32'd2);
    chk("t3 bus_w", {16'b0, bus_w}, 32'h1234);
    do_reset();
    alu_valid = 1'b1;
    dbg_valid = 1'b1; dbg_addr = 3'd7; dbg_data = 16'hD00D;
    n = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (dbg_ready) begin
        n++;
        at = i;
      end
      tick();
      if (at == i) begin
        dbg_valid = 1'b0;
        chk("t4 bus_w", {16'b0, bus_w}, 32'hD00D);
        chk("t4 grant_id", {30'b0, grant_id}, 32'd2);
      end
    end
    chk("t4 dbg grants", n, 32'd1);
    chk("t4 dbg cycle", at, 32'd4);
    do_reset();
    alu_valid = 1'b1;
    ld_valid = 1'b1; ld_addr = 3'd4; ld_data = 16'h5A5A;
    for (int i = 0; i < 2; i++) begin
      #2 chk("t5 early ld_ready", {31'b0, ld_ready}, 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    tick();
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2 chk("t5 ld_ready", {31'b0, ld_ready}, {31'b0, i == 4});
      tick();
    end
    ld_valid = 1'b0;
    do_reset();
    alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h5555;
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'h1111;
    dbg_valid = 1'b1; dbg_addr = 3'd2; dbg_data = 16'h2222;
    for (int i = 0; i < 6; i++) tick();
    chk("t6 pre en_w", {31'b0, en_w}, 32'd1);
    chk("t6 pre addr_w", {29'b0, addr_w}, 32'd6);
    #2 reset = 1'b1;
    #1;
    chk("t6 en_w", {31'b0, en_w}, 32'd0);
    chk("t6 addr_w", {29'b0, addr_w}, 32'd0);
    chk("t6 bus_w", {16'b0, bus_w}, 32'd0);
    chk("t6 grant_id", {30'b0, grant_id}, 32'd3);
    chk("t6 readies", {29'b0, alu_ready, ld_ready, dbg_ready}, 32'd0);
    tick();
    reset = 1'b0;
    alu_valid = 1'b0;
    #2;
    chk("t6 post ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("t6 post dbg_ready", {31'b0, dbg_ready}, 32'd0);
    tick();
    ld_valid = 1'b0; dbg_valid = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
